// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants and CA grid geometry, also used by the renderer.
package vga_timing_pkg;

    localparam int H_DISPLAY = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;

    localparam int V_DISPLAY = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam bit SYNC_POL  = 1'b0;

    localparam int GRID_W    = 100;
    localparam int LOG_CELL  = 2;
    localparam int FC_W      = 16;

    // Position and cell-index widths are fixed by the port map.
    localparam int POS_W     = 10;
    localparam int GX_W      = 8;

    // Left blanking margin that centres the grid in the visible line.
    function automatic int pad_l(input int h_disp, input int grid_w, input int log_cell);
        return (h_disp - (grid_w << log_cell)) / 2;
    endfunction

    localparam int PAD_L     = pad_l(H_DISPLAY, GRID_W, LOG_CELL);

endpackage

// File: rtl/vga_timing_if.sv
// Raster timing bundle: the generator drives it, renderers consume it.
interface vga_timing_if
    import vga_timing_pkg::*;
#(
    parameter int FC_W = vga_timing_pkg::FC_W
);
    logic              hsync;
    logic              vsync;
    logic              display_on;
    logic [POS_W-1:0]  hpos;
    logic [POS_W-1:0]  vpos;
    logic              line_start;
    logic              frame_start;
    logic              in_grid;
    logic [GX_W-1:0]   grid_x;
    logic              cell_tick;
    logic              cell_row0;
    logic [FC_W-1:0]   frame_cnt;

    modport master (
        output hsync, vsync, display_on, hpos, vpos, line_start, frame_start,
               in_grid, grid_x, cell_tick, cell_row0, frame_cnt
    );

    modport slave (
        input  hsync, vsync, display_on, hpos, vpos, line_start, frame_start,
               in_grid, grid_x, cell_tick, cell_row0, frame_cnt
    );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus registered active/sync decodes.
// Decodes come from the next value so they line up with the registered count.
module vga_axis_counter #(
    parameter int TOTAL      = 800,
    parameter int ACTIVE     = 640,
    parameter int SYNC_START = 656,
    parameter int SYNC_LEN   = 96,
    parameter bit SYNC_POL   = 1'b0,
    parameter int W          = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic [W-1:0] nxt,
    output logic         wrap,
    output logic         active,
    output logic         sync
);

    // Next position: hold, step, or wrap to zero at the last count.
    always_comb begin
        wrap = inc && (cnt == W'(TOTAL - 1));
        nxt  = cnt;
        if (inc)
            nxt = wrap ? '0 : cnt + 1'b1;
    end

    // Register the count and the decodes of the value it is about to take.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            active <= 1'b0;
            sync   <= ~SYNC_POL;
        end else begin
            cnt    <= nxt;
            active <= (nxt < W'(ACTIVE));
            sync   <= ((nxt >= W'(SYNC_START)) && (nxt < W'(SYNC_START + SYNC_LEN)))
                      ? SYNC_POL : ~SYNC_POL;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing source with CA grid strobes; every output is registered and
// describes the current (hpos,vpos) with no extra latency.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_DISPLAY = vga_timing_pkg::H_DISPLAY,
    parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
    parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int H_BACK    = vga_timing_pkg::H_BACK,
    parameter int V_DISPLAY = vga_timing_pkg::V_DISPLAY,
    parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
    parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int V_BACK    = vga_timing_pkg::V_BACK,
    parameter bit SYNC_POL  = vga_timing_pkg::SYNC_POL,
    parameter int GRID_W    = vga_timing_pkg::GRID_W,
    parameter int LOG_CELL  = vga_timing_pkg::LOG_CELL,
    parameter int FC_W      = vga_timing_pkg::FC_W
) (
    input  logic         clk,
    input  logic         rst_n,
    vga_timing_if.master vga
);

    localparam int HT  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int VT  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int PAD = pad_l(H_DISPLAY, GRID_W, LOG_CELL);

    logic [POS_W-1:0] h_cnt, h_nxt, v_cnt, v_nxt;
    logic             h_wrap, v_wrap, h_act, v_act, h_sync, v_sync;

    vga_axis_counter #(
        .TOTAL(HT), .ACTIVE(H_DISPLAY), .SYNC_START(H_DISPLAY + H_FRONT),
        .SYNC_LEN(H_SYNC), .SYNC_POL(SYNC_POL), .W(POS_W)
    ) u_h (
        .clk(clk), .rst_n(rst_n), .inc(1'b1),
        .cnt(h_cnt), .nxt(h_nxt), .wrap(h_wrap), .active(h_act), .sync(h_sync)
    );

    // Vertical steps on the horizontal wrap, so its sync edges land at hpos==0.
    vga_axis_counter #(
        .TOTAL(VT), .ACTIVE(V_DISPLAY), .SYNC_START(V_DISPLAY + V_FRONT),
        .SYNC_LEN(V_SYNC), .SYNC_POL(SYNC_POL), .W(POS_W)
    ) u_v (
        .clk(clk), .rst_n(rst_n), .inc(h_wrap),
        .cnt(v_cnt), .nxt(v_nxt), .wrap(v_wrap), .active(v_act), .sync(v_sync)
    );

    logic [POS_W-1:0] x_nxt;
    logic             disp_nxt, grid_nxt, tick_nxt, frame_wrap;

    // Grid-relative column of the next pixel; left margin wraps to large values
    // and so falls outside the grid by the same compare as the right margin.
    always_comb begin
        x_nxt      = h_nxt - POS_W'(PAD);
        disp_nxt   = (h_nxt < POS_W'(H_DISPLAY)) && (v_nxt < POS_W'(V_DISPLAY));
        grid_nxt   = disp_nxt && ((x_nxt >> LOG_CELL) < POS_W'(GRID_W));
        tick_nxt   = grid_nxt && (&x_nxt[LOG_CELL-1:0]);
        frame_wrap = h_wrap && v_wrap;
    end

    logic              in_grid, cell_tick, line_start, frame_start, cell_row0;
    logic [GX_W-1:0]   grid_x;
    logic [FC_W-1:0]   frame_cnt;

    // Grid decode, line/frame strobes and completed-frame count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_grid     <= 1'b0;
            grid_x      <= '0;
            cell_tick   <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            cell_row0   <= 1'b1;
            frame_cnt   <= '0;
        end else begin
            in_grid     <= grid_nxt;
            grid_x      <= x_nxt[LOG_CELL+GX_W-1:LOG_CELL];
            cell_tick   <= tick_nxt;
            line_start  <= h_wrap;
            frame_start <= frame_wrap;
            cell_row0   <= (v_nxt[LOG_CELL-1:0] == '0);
            if (frame_wrap)
                frame_cnt <= frame_cnt + 1'b1;
        end
    end

    assign vga.hpos        = h_cnt;
    assign vga.vpos        = v_cnt;
    assign vga.hsync       = h_sync;
    assign vga.vsync       = v_sync;
    assign vga.display_on  = h_act && v_act;
    assign vga.in_grid     = in_grid;
    assign vga.grid_x      = grid_x;
    assign vga.cell_tick   = cell_tick;
    assign vga.line_start  = line_start;
    assign vga.frame_start = frame_start;
    assign vga.cell_row0   = cell_row0;
    assign vga.frame_cnt   = frame_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen. dut_a keeps the full 800-pixel line but a short
// 15-line frame (8 visible, vsync on lines 10..11) so whole frames fit the run;
// dut_b is a tiny raster (24x7) with a 4-bit frame counter for the wrap test.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst_n_a = 1'b0;
    logic rst_n_b = 1'b0;

    always #5 clk = ~clk;

    vga_timing_if #(.FC_W(16)) if_a ();
    vga_timing_if #(.FC_W(4))  if_b ();

    vga_timing_gen #(
        .V_DISPLAY(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .FC_W(16)
    ) dut_a (.clk(clk), .rst_n(rst_n_a), .vga(if_a));

    vga_timing_gen #(
        .H_DISPLAY(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .GRID_W(2), .LOG_CELL(2), .FC_W(4)
    ) dut_b (.clk(clk), .rst_n(rst_n_b), .vga(if_b));

    localparam int FRAME_A = 800 * 15;
    localparam int FRAME_B = 24 * 7;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        int   h;
        int   v;
        logic hs, vs, de, ig;
        int   gx;
        logic gxc, ct, ls, fs, r0;
    } vec_t;

    vec_t tbl [22];

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic goto_a(input int h, input int v);
        int n;
        n = 0;
        while (!(int'(if_a.hpos) == h && int'(if_a.vpos) == v) && n < 2 * FRAME_A) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2 * FRAME_A) begin
            n_vec++;
            n_bad++;
            $display("FAIL goto(%0d,%0d): position never reached, now (%0d,%0d)",
                     h, v, if_a.hpos, if_a.vpos);
        end
    endtask

    initial begin
        logic [7:0] got, want;
        int hs_low, hs_fall, hs_rise, vs_low, de_hi, ct_all, ct_l3, ct_bad, fs_cnt, fc0;
        logic prev_hs;
        int k, first_fs, max_h, max_v;

        //         h    v   hs vs de ig  gx gxc ct ls fs r0
        tbl[0]  = '{1,   0,  1, 1, 1, 0,  0, 0, 0, 0, 0, 1};
        tbl[1]  = '{119, 0,  1, 1, 1, 0,  0, 0, 0, 0, 0, 1};
        tbl[2]  = '{120, 0,  1, 1, 1, 1,  0, 1, 0, 0, 0, 1};
        tbl[3]  = '{123, 0,  1, 1, 1, 1,  0, 1, 1, 0, 0, 1};
        tbl[4]  = '{124, 0,  1, 1, 1, 1,  1, 1, 0, 0, 0, 1};
        tbl[5]  = '{519, 0,  1, 1, 1, 1, 99, 1, 1, 0, 0, 1};
        tbl[6]  = '{520, 0,  1, 1, 1, 0,  0, 0, 0, 0, 0, 1};
        tbl[7]  = '{639, 0,  1, 1, 1, 0,  0, 0, 0, 0, 0, 1};
        tbl[8]  = '{640, 0,  1, 1, 0, 0,  0, 0, 0, 0, 0, 1};
        tbl[9]  = '{655, 0,  1, 1, 0, 0,  0, 0, 0, 0, 0, 1};
        tbl[10] = '{656, 0,  0, 1, 0, 0,  0, 0, 0, 0, 0, 1};
        tbl[11] = '{751, 0,  0, 1, 0, 0,  0, 0, 0, 0, 0, 1};
        tbl[12] = '{752, 0,  1, 1, 0, 0,  0, 0, 0, 0, 0, 1};
        tbl[13] = '{0,   1,  1, 1, 1, 0,  0, 0, 0, 1, 0, 0};
        tbl[14] = '{0,   4,  1, 1, 1, 0,  0, 0, 0, 1, 0, 1};
        tbl[15] = '{200, 7,  1, 1, 1, 1, 20, 1, 0, 0, 0, 0};
        tbl[16] = '{200, 8,  1, 1, 0, 0,  0, 0, 0, 0, 0, 1};
        tbl[17] = '{0,  10,  1, 0, 0, 0,  0, 0, 0, 1, 0, 0};
        tbl[18] = '{799, 11, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0};
        tbl[19] = '{0,  12,  1, 1, 0, 0,  0, 0, 0, 1, 0, 1};
        tbl[20] = '{799, 14, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0};
        tbl[21] = '{0,   0,  1, 1, 1, 0,  0, 0, 0, 1, 1, 1};

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst hpos", int'(if_a.hpos), 0);
        chk("rst vpos", int'(if_a.vpos), 0);
        chk("rst flags {hs,vs,de,ig,ct,ls,fs,r0}",
            int'({if_a.hsync, if_a.vsync, if_a.display_on, if_a.in_grid,
                  if_a.cell_tick, if_a.line_start, if_a.frame_start, if_a.cell_row0}),
            int'(8'b1100_0001));
        chk("rst grid_x", int'(if_a.grid_x), 0);
        chk("rst frame_cnt", int'(if_a.frame_cnt), 0);

        // Table of positions across the first frame after release.
        rst_n_a = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 22; i++) begin
            goto_a(tbl[i].h, tbl[i].v);
            got  = {if_a.hsync, if_a.vsync, if_a.display_on, if_a.in_grid,
                    if_a.cell_tick, if_a.line_start, if_a.frame_start, if_a.cell_row0};
            want = {tbl[i].hs, tbl[i].vs, tbl[i].de, tbl[i].ig,
                    tbl[i].ct, tbl[i].ls, tbl[i].fs, tbl[i].r0};
            chk($sformatf("vec%0d (%0d,%0d) flags {hs,vs,de,ig,ct,ls,fs,r0}",
                          i, tbl[i].h, tbl[i].v), int'(got), int'(want));
            if (tbl[i].gxc)
                chk($sformatf("vec%0d (%0d,%0d) grid_x", i, tbl[i].h, tbl[i].v),
                    int'(if_a.grid_x), tbl[i].gx);
        end
        chk("frame_cnt after first wrap", int'(if_a.frame_cnt), 1);

        // One whole frame from (0,0): sync widths, visible area, cell ticks, strobes.
        fc0 = int'(if_a.frame_cnt);
        hs_low = 0; hs_fall = -1; hs_rise = -1; prev_hs = 1'b1;
        vs_low = 0; de_hi = 0; ct_all = 0; ct_l3 = 0; ct_bad = 0; fs_cnt = 0;
        for (int i = 0; i < FRAME_A; i++) begin
            if (int'(if_a.vpos) == 1) begin
                if (!if_a.hsync) hs_low++;
                if (prev_hs && !if_a.hsync) hs_fall = int'(if_a.hpos);
                if (!prev_hs && if_a.hsync) hs_rise = int'(if_a.hpos);
            end
            prev_hs = if_a.hsync;
            if (!if_a.vsync)    vs_low++;
            if (if_a.display_on) de_hi++;
            if (if_a.frame_start) fs_cnt++;
            if (if_a.cell_tick) begin
                ct_all++;
                if (int'(if_a.vpos) == 3) ct_l3++;
                if (int'(if_a.vpos) >= 8 || int'(if_a.hpos) < 123 || int'(if_a.hpos) > 519 ||
                    ((int'(if_a.hpos) - 123) % 4) != 0)
                    ct_bad++;
            end
            @(negedge clk);
        end
        chk("hsync low clks in line", hs_low, 96);
        chk("hsync fall hpos", hs_fall, 656);
        chk("hsync rise hpos", hs_rise, 752);
        chk("vsync low clks in frame", vs_low, 1600);
        chk("display_on clks in frame", de_hi, 640 * 8);
        chk("cell_tick per frame", ct_all, 800);
        chk("cell_tick in line 3", ct_l3, 100);
        chk("cell_tick off-grid", ct_bad, 0);
        chk("frame_start inside frame", fs_cnt, 1);
        chk("frame_start one frame later", int'(if_a.frame_start), 1);
        chk("pos after one frame", int'({if_a.vpos, if_a.hpos}), 0);
        chk("frame_cnt step", int'(if_a.frame_cnt), fc0 + 1);

        // Reset in the middle of hsync and vsync.
        goto_a(700, 10);
        chk("pre-reset sync {hs,vs}", int'({if_a.hsync, if_a.vsync}), 0);
        rst_n_a = 1'b0;
        @(negedge clk);
        chk("mid rst hpos", int'(if_a.hpos), 0);
        chk("mid rst vpos", int'(if_a.vpos), 0);
        chk("mid rst flags {hs,vs,de,ig,ct,ls,fs,r0}",
            int'({if_a.hsync, if_a.vsync, if_a.display_on, if_a.in_grid,
                  if_a.cell_tick, if_a.line_start, if_a.frame_start, if_a.cell_row0}),
            int'(8'b1100_0001));
        chk("mid rst frame_cnt", int'(if_a.frame_cnt), 0);
        rst_n_a = 1'b1;
        @(negedge clk);
        chk("release hpos", int'(if_a.hpos), 1);
        chk("release vpos", int'(if_a.vpos), 0);
        chk("release {de,ls,fs}",
            int'({if_a.display_on, if_a.line_start, if_a.frame_start}), int'(3'b100));

        // Tiny raster, 4-bit frame counter: 17 frames wrap it through 15 to 0.
        rst_n_b = 1'b1;
        k = 0; first_fs = -1; max_h = 0; max_v = 0;
        for (int n = 1; n <= 17 * FRAME_B; n++) begin
            @(negedge clk);
            if (int'(if_b.hpos) > max_h) max_h = int'(if_b.hpos);
            if (int'(if_b.vpos) > max_v) max_v = int'(if_b.vpos);
            if (if_b.frame_start) begin
                k++;
                if (first_fs < 0) first_fs = n;
                chk($sformatf("b frame_cnt at pulse %0d", k), int'(if_b.frame_cnt), k % 16);
            end
        end
        chk("b first frame_start clk", first_fs, FRAME_B);
        chk("b frame_start pulses", k, 17);
        chk("b max hpos", max_h, 23);
        chk("b max vpos", max_v, 6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
